// File: rtl/rrf_pkg.sv
// Shared constants and entry-state types for the rename register file.
// Optional feature macro (used in rename_reg_file.sv): RRF_WB_BYPASS_EN
package rrf_pkg;

   localparam int RRF_DATA_W = 32;
   localparam int RRF_DEPTH  = 16;

   // Per-entry bookkeeping bits, kept apart from the data array so the
   // data width can follow the DATA_W parameter of each instance.
   typedef struct packed {
      logic allocated;
      logic valid;
   } rrf_flags_t;

   // Full entry view at the default data width.
   typedef struct packed {
      logic                  allocated;
      logic                  valid;
      logic [RRF_DATA_W-1:0] data;
   } rrf_entry_t;

   function automatic int rrf_tag_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/rename_reg_file_if.sv
// Allocation, writeback, read, commit and status signals of the rename
// register file. master = producer of requests, slave = the register file.
interface rename_reg_file_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16
);
   localparam int TAG_W = $clog2(DEPTH);
   localparam int CNT_W = TAG_W + 1;

   logic              alloc_req;
   logic              alloc_grant;
   logic [TAG_W-1:0]  alloc_tag;

   logic              wb_en;
   logic [TAG_W-1:0]  wb_tag;
   logic [DATA_W-1:0] wb_data;

   logic [TAG_W-1:0]  rd_tag0;
   logic [TAG_W-1:0]  rd_tag1;
   logic [DATA_W-1:0] rd_data0;
   logic [DATA_W-1:0] rd_data1;
   logic              rd_valid0;
   logic              rd_valid1;

   logic              commit_en;
   logic              commit_valid;
   logic [TAG_W-1:0]  commit_tag;
   logic [DATA_W-1:0] commit_data;

   logic              flush;
   logic              full;
   logic              empty;
   logic [CNT_W-1:0]  count;

   modport master (
      output alloc_req, wb_en, wb_tag, wb_data, rd_tag0, rd_tag1, commit_en, flush,
      input  alloc_grant, alloc_tag, rd_data0, rd_data1, rd_valid0, rd_valid1,
             commit_valid, commit_tag, commit_data, full, empty, count
   );

   modport slave (
      input  alloc_req, wb_en, wb_tag, wb_data, rd_tag0, rd_tag1, commit_en, flush,
      output alloc_grant, alloc_tag, rd_data0, rd_data1, rd_valid0, rd_valid1,
             commit_valid, commit_tag, commit_data, full, empty, count
   );

endinterface

// File: rtl/rrf_ptr_ctrl.sv
// Head/tail pointers and occupancy count of the rename circular buffer.
// Pointers are TAG_W wide, so DEPTH-1 wraps to 0 by natural overflow.
module rrf_ptr_ctrl
   import rrf_pkg::*;
#(
   parameter int DEPTH = RRF_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   output logic [$clog2(DEPTH)-1:0] head,
   output logic [$clog2(DEPTH)-1:0] tail,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int TAG_W = rrf_tag_w(DEPTH);
   localparam int CNT_W = TAG_W + 1;

   // Pointer and count update; reset and flush both return to the origin.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Occupancy flags straight from the count.
   always_comb begin
      full  = (count == CNT_W'(DEPTH));
      empty = (count == '0);
   end

endmodule

// File: rtl/rename_reg_file.sv
// Rename register file: circular buffer of speculative result entries with
// two combinational read ports, in-order commit and single-cycle flush.
// Optional macro RRF_WB_BYPASS_EN: forward a same-cycle writeback to the
// read ports and the commit head.
module rename_reg_file
   import rrf_pkg::*;
#(
   parameter int DATA_W = RRF_DATA_W,
   parameter int DEPTH  = RRF_DEPTH
) (
   input logic              clk,
   input logic              reset,
   rename_reg_file_if.slave bus
);
   localparam int TAG_W = rrf_tag_w(DEPTH);
   localparam int CNT_W = TAG_W + 1;

   rrf_flags_t        flags_q [DEPTH];
   logic [DATA_W-1:0] data_q  [DEPTH];

   logic [TAG_W-1:0]  head;
   logic [TAG_W-1:0]  tail;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              empty;
   logic              grant;
   logic              wb_hit;
   logic              commit_fire;
   logic              head_valid;
   logic [DATA_W-1:0] head_data;

   rrf_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
      .clk   (clk),
      .reset (reset),
      .flush (bus.flush),
      .push  (grant),
      .pop   (commit_fire),
      .head  (head),
      .tail  (tail),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // Grant, read ports and commit head view (with optional writeback bypass).
   always_comb begin
      grant  = bus.alloc_req && !full && !bus.flush;
      wb_hit = bus.wb_en && flags_q[bus.wb_tag].allocated;

      bus.rd_data0  = data_q[bus.rd_tag0];
      bus.rd_valid0 = flags_q[bus.rd_tag0].allocated && flags_q[bus.rd_tag0].valid;
      bus.rd_data1  = data_q[bus.rd_tag1];
      bus.rd_valid1 = flags_q[bus.rd_tag1].allocated && flags_q[bus.rd_tag1].valid;
      head_data     = data_q[head];
      head_valid    = flags_q[head].valid;
`ifdef RRF_WB_BYPASS_EN
      if (wb_hit && (bus.rd_tag0 == bus.wb_tag)) begin
         bus.rd_data0  = bus.wb_data;
         bus.rd_valid0 = 1'b1;
      end
      if (wb_hit && (bus.rd_tag1 == bus.wb_tag)) begin
         bus.rd_data1  = bus.wb_data;
         bus.rd_valid1 = 1'b1;
      end
      if (wb_hit && (head == bus.wb_tag)) begin
         head_data  = bus.wb_data;
         head_valid = 1'b1;
      end
`endif
      bus.commit_valid = !empty && head_valid;
      commit_fire      = bus.commit_en && bus.commit_valid && !bus.flush;

      bus.alloc_grant = grant;
      bus.alloc_tag   = tail;
      bus.commit_tag  = head;
      bus.commit_data = head_data;
      bus.full        = full;
      bus.empty       = empty;
      bus.count       = count;
   end

   // Entry state and data; flush drops bookkeeping but keeps stored values.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            flags_q[i] <= '0;
            data_q[i]  <= '0;
         end
      end else if (bus.flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            flags_q[i] <= '0;
         end
      end else begin
         if (grant) begin
            flags_q[tail].allocated <= 1'b1;
            flags_q[tail].valid     <= 1'b0;
         end
         if (wb_hit) begin
            data_q[bus.wb_tag]        <= bus.wb_data;
            flags_q[bus.wb_tag].valid <= 1'b1;
         end
         // Retirement last so a bypassed writeback to the head still frees it.
         if (commit_fire) begin
            flags_q[head].allocated <= 1'b0;
            flags_q[head].valid     <= 1'b0;
         end
      end
   end

endmodule

// File: doc/rename_reg_file.md
RENAME_REG_FILE -- requirements
Module: rename_reg_file

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter DATA_W, default 32: width of each rename entry value.
REQ-003 Parameter DEPTH, default 16: number of rename entries, power of two, minimum 4.
REQ-004 Derived constants SHALL be TAG_W = log2(DEPTH) and CNT_W = TAG_W+1.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 alloc_req  in  1  request one new rename entry.
REQ-008 alloc_grant  out  1  allocation accepted this cycle.
REQ-009 alloc_tag  out  TAG_W  tag of the entry allocated (tail pointer).
REQ-010 wb_en, wb_tag, wb_data  in  1/TAG_W/DATA_W  execution writeback.
REQ-011 rd_tag0, rd_tag1  in  TAG_W  read port tags.
REQ-012 rd_data0, rd_data1  out  DATA_W  entry values.
REQ-013 rd_valid0, rd_valid1  out  1  entry allocated and written back.
REQ-014 commit_en  in  1  retire the head entry.
REQ-015 commit_valid, commit_tag, commit_data  out  1/TAG_W/DATA_W  head status, head tag, head value.
REQ-016 flush  in  1  discard all speculative entries.
REQ-017 full, empty  out  1  occupancy flags; count  out  CNT_W  number of allocated entries.

Function
REQ-018 Entries SHALL form a circular buffer with head (oldest) and tail (next free) pointers of TAG_W bits, each wrapping from DEPTH-1 to 0.
REQ-019 alloc_grant SHALL equal alloc_req AND NOT full AND NOT flush, combinationally; alloc_tag SHALL always show the tail.
REQ-020 On a grant, the entry at tail SHALL be marked allocated with valid=0, and tail SHALL advance by 1 at the next edge.
REQ-021 A wb_en to an allocated entry SHALL write wb_data and set valid=1 at the next edge; a wb_en to an unallocated entry SHALL be ignored.
REQ-022 Read ports SHALL be combinational: rd_data = stored value, rd_valid = allocated AND valid.
REQ-023 commit_valid SHALL equal NOT empty AND head entry valid; commit_tag/commit_data SHALL reflect the head.
REQ-024 commit_en with commit_valid=1 SHALL clear the head allocated bit and advance head; commit_en with commit_valid=0 SHALL be ignored.
REQ-025 Simultaneous grant and commit SHALL leave count unchanged; grant alone increments it, commit alone decrements it.
REQ-026 full SHALL be count==DEPTH; empty SHALL be count==0; a request while full SHALL get no grant even if a commit occurs in the same cycle.
REQ-027 flush SHALL have the highest priority: at the next edge head=tail=0, count=0, all allocated/valid bits cleared; concurrent alloc, wb and commit are discarded; data storage is unchanged.

Reset
REQ-028 reset SHALL have priority over flush and produce the flush state plus all data storage cleared to 0.
REQ-029 Reset values: alloc_grant=0, alloc_tag=0, count=0, empty=1, full=0, commit_valid=0, commit_tag=0, commit_data=0, rd_valid0/1=0.
REQ-030 Reset asserted mid-operation SHALL abandon all in-flight allocations with no partial update.

Configuration
REQ-031 Macro RRF_WB_BYPASS_EN compiled in: a read port or the commit head matching wb_tag with wb_en on an allocated entry SHALL return wb_data with valid=1 in the same cycle, and commit of that head SHALL be allowed that cycle.
REQ-032 Without RRF_WB_BYPASS_EN: written values SHALL be visible only from the cycle after the writeback.

Structure
REQ-033 Shared package rrf_pkg SHALL hold default DATA_W/DEPTH constants and the entry-state typedef (allocated, valid, data).
REQ-034 The pointer/count logic SHALL be a sub-module rrf_ptr_ctrl (head, tail, count, full, empty, wrap).

Verification
REQ-035 After reset: 4 allocs -> alloc_tag 0,1,2,3, count=4, rd_valid0 on tag 2 is 0.
REQ-036 wb tag 2 with 0xDEADBEEF -> next cycle rd_tag1=2 gives 0xDEADBEEF, valid=1; commit_valid stays 0 until tag 0 is written.
REQ-037 Fill to DEPTH=16 -> full=1, 17th request gets no grant; commit then alloc -> tail wraps to tag 0 without error.
REQ-038 Alloc and commit in the same cycle at count=5 -> count stays 5, head and tail both advance.
REQ-039 flush with alloc_req, wb_en and commit_en all high -> next cycle count=0, empty=1, all rd_valid=0.
REQ-040 With RRF_WB_BYPASS_EN, wb tag 3 = 0x12345678 while rd_tag0=3 -> same-cycle rd_data0=0x12345678, rd_valid0=1; without the macro, rd_valid0=0 that cycle.
